jram: RTL and testbench

Parametrised successor to the jcscpu main memory: a `DEPTH`-word by `WIDTH`-bit RAM behind a clocked memory address register (MAR), adding an on-chip program loader. The CPU side keeps the set-MAR / set / enable bus protocol. The loader side is a valid/ready stream that writes a program image from any external source, such as a testbench or UART front end, starting at a chosen base address. It sits between the CPU address/data buses and an optional boot source; while a load is in progress it holds the CPU off the memory.

---
 rtl/jram_if.sv | 27 ++
 rtl/jram.sv | 57 +++++
 tb/tb_jram.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/jram_if.sv
// jram_if: CPU bus and program-loader stream signals for jram.
interface jram_if #(parameter int WIDTH = 8, parameter int AWIDTH = 8);
  logic [AWIDTH-1:0] bas;
  logic [AWIDTH-1:0] ld_base;
  logic [WIDTH-1:0] bis;
  logic [WIDTH-1:0] bos;
  logic [WIDTH-1:0] ld_data;
  logic [AWIDTH:0] ld_count;
  logic sa;
  logic s;
  logic e;
  logic ld_start;
  logic ld_valid;
  logic ld_last;
  logic ld_ready;
  logic busy;
  logic ld_done;
  logic ld_err;
  modport master(
    output bas, sa, bis, s, e, ld_start, ld_base, ld_data, ld_valid, ld_last,
    input bos, ld_ready, busy, ld_done, ld_count, ld_err
  );
  modport slave(
    input bas, sa, bis, s, e, ld_start, ld_base, ld_data, ld_valid, ld_last,
    output bos, ld_ready, busy, ld_done, ld_count, ld_err
  );
endinterface

// File: rtl/jram.sv
// jram: MAR-addressed RAM with a valid/ready program loader that locks out the CPU while loading.
module jram #(
  parameter int WIDTH = 8,
  parameter int AWIDTH = 8
) (
  input logic clk,
  input logic reset,
  jram_if.slave bus
);
  localparam int DEPTH = 1 << AWIDTH;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_n;
  logic [AWIDTH-1:0] mar, ptr, wa;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] mem [DEPTH];
  logic accept, we, at_end;
  always_comb begin
    accept = state == LOAD && bus.ld_valid;
    at_end = &ptr;
    state_n = state == IDLE ? (bus.ld_start ? LOAD : IDLE)
            : state == LOAD ? (accept && (bus.ld_last || at_end) ? DONE : LOAD)
            : IDLE;
    we = accept || (bus.s && !bus.busy);
    wa = accept ? ptr : mar;
    wd = accept ? bus.ld_data : bus.bis;
  end
  assign bus.busy = state != IDLE;
  assign bus.ld_ready = state == LOAD;
  assign bus.ld_done = state == DONE;
  assign bus.bos = bus.e && !bus.busy ? mem[mar] : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mar <= '0;
      ptr <= '0;
      bus.ld_count <= '0;
      bus.ld_err <= 1'b0;
    end else begin
      state <= state_n;
      if (bus.sa && !bus.busy) mar <= bus.bas;
      if (state == IDLE && bus.ld_start) begin
        ptr <= bus.ld_base;
        bus.ld_count <= '0;
        bus.ld_err <= 1'b0;
      end
      // Overflow truncates at the top word; the DONE transition stops ptr wrapping into use.
      if (accept) begin
        ptr <= ptr + 1'b1;
        bus.ld_count <= bus.ld_count + 1'b1;
        bus.ld_err <= at_end && !bus.ld_last;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
endmodule

// File: tb/tb_jram.sv
// tb_jram: directed checks of jram CPU access, program load, overflow, lockout and reset abort.
module tb_jram;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  int busy_cyc = 0;
  int done_cnt = 0;
  logic [7:0] prog [12] = '{8'h20, 8'h00, 8'h21, 8'h01, 8'h80, 8'h02,
                            8'h40, 8'h03, 8'h14, 8'h16, 8'h36, 8'h61};
  jram_if #(.WIDTH(8), .AWIDTH(8)) b ();
  jram #(.WIDTH(8), .AWIDTH(8)) dut (.clk(clk), .reset(reset), .bus(b.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    if (b.busy) busy_cyc++;
    if (b.ld_done) done_cnt++;
    @(posedge clk);
    #1;
  endtask
  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    b.sa = 1'b1; b.bas = a;
    tick();
    b.sa = 1'b0; b.s = 1'b1; b.bis = d;
    tick();
    b.s = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    b.sa = 1'b1; b.bas = a;
    tick();
    b.sa = 1'b0; b.e = 1'b1;
    #1;
    chk(tag, 32'(b.bos), 32'(exp));
    b.e = 1'b0;
  endtask
  initial begin
    b.bas = '0; b.sa = 0; b.bis = '0; b.s = 0; b.e = 0;
    b.ld_start = 0; b.ld_base = '0; b.ld_data = '0; b.ld_valid = 0; b.ld_last = 0;
    reset = 1'b1;
    #2;
    chk("rst_busy", 32'(b.busy), 0);
    chk("rst_ready", 32'(b.ld_ready), 0);
    chk("rst_done", 32'(b.ld_done), 0);
    chk("rst_count", 32'(b.ld_count), 0);
    chk("rst_err", 32'(b.ld_err), 0);
    chk("rst_bos", 32'(b.bos), 0);
    tick();
    reset = 1'b0;
    tick();
    // CPU write then read back
    cpu_wr(8'h10, 8'hA5);
    b.e = 1'b1; #1;
    chk("cpu_rd", 32'(b.bos), 32'h A5);
    b.e = 1'b0; #1;
    chk("cpu_e0", 32'(b.bos), 0);
    // simultaneous sa/s writes old MAR
    cpu_wr(8'h02, 8'h77);
    b.sa = 1'b1; b.bas = 8'h01;
    tick();
    b.bas = 8'h02; b.s = 1'b1; b.bis = 8'h3C;
    tick();
    b.sa = 1'b0; b.s = 1'b0; b.e = 1'b1; #1;
    chk("sim_mar2", 32'(b.bos), 32'h77);
    b.e = 1'b0;
    rd_chk("sim_mem1", 8'h01, 8'h3C);
    // 12-word program with one stall
    b.ld_start = 1'b1; b.ld_base = 8'h00;
    busy_cyc = 0; done_cnt = 0;
    tick();
    b.ld_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        b.ld_valid = 1'b0;
        tick();
      end
      b.ld_valid = 1'b1; b.ld_data = prog[i]; b.ld_last = (i == 11);
      tick();
    end
    b.ld_valid = 1'b0; b.ld_last = 1'b0;
    chk("prg_done", 32'(b.ld_done), 1);
    tick();
    tick();
    chk("prg_busy", 32'(busy_cyc), 14);
    chk("prg_pulse", 32'(done_cnt), 1);
    chk("prg_count", 32'(b.ld_count), 12);
    chk("prg_err", 32'(b.ld_err), 0);
    rd_chk("prg_m0", 8'h00, 8'h20);
    rd_chk("prg_m11", 8'h0B, 8'h61);
    // overflow from 0xFE; valid during ld_start must not be accepted
    b.ld_start = 1'b1; b.ld_base = 8'hFE; b.ld_valid = 1'b1; b.ld_data = 8'hA1;
    tick();
    b.ld_start = 1'b0;
    chk("ovf_ready", 32'(b.ld_ready), 1);
    tick();
    b.ld_data = 8'hA2;
    tick();
    chk("ovf_rdy_drop", 32'(b.ld_ready), 0);
    chk("ovf_done", 32'(b.ld_done), 1);
    b.ld_data = 8'hA3;
    tick();
    b.ld_data = 8'hA4;
    tick();
    b.ld_valid = 1'b0;
    chk("ovf_count", 32'(b.ld_count), 2);
    chk("ovf_err", 32'(b.ld_err), 1);
    rd_chk("ovf_fe", 8'hFE, 8'hA1);
    rd_chk("ovf_ff", 8'hFF, 8'hA2);
    rd_chk("ovf_00", 8'h00, 8'h20);
    // CPU lockout and ignored second ld_start
    cpu_wr(8'h11, 8'h5A);
    b.ld_start = 1'b1; b.ld_base = 8'h40;
    tick();
    b.e = 1'b1; b.sa = 1'b1; b.bas = 8'h10; b.s = 1'b1; b.bis = 8'hFF; b.ld_base = 8'h80;
    #1;
    chk("lk_bos", 32'(b.bos), 0);
    tick();
    b.sa = 1'b0; b.s = 1'b0; b.e = 1'b0; b.ld_start = 1'b0;
    b.ld_valid = 1'b1; b.ld_data = 8'h55;
    tick();
    b.ld_data = 8'h66; b.ld_last = 1'b1;
    tick();
    b.ld_valid = 1'b0; b.ld_last = 1'b0;
    tick();
    b.e = 1'b1; #1;
    chk("lk_mar", 32'(b.bos), 32'h5A);
    b.e = 1'b0;
    chk("lk_count", 32'(b.ld_count), 2);
    chk("lk_err", 32'(b.ld_err), 0);
    rd_chk("lk_m10", 8'h10, 8'hA5);
    rd_chk("lk_m40", 8'h40, 8'h55);
    rd_chk("lk_m41", 8'h41, 8'h66);
    // reset after 3 accepts
    b.ld_start = 1'b1; b.ld_base = 8'h30;
    tick();
    b.ld_start = 1'b0; b.ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b.ld_data = 8'(8'h11 * (i + 1));
      tick();
    end
    b.ld_valid = 1'b0;
    chk("ra_count", 32'(b.ld_count), 3);
    b.e = 1'b1; b.ld_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk("ra_busy", 32'(b.busy), 0);
    chk("ra_ready", 32'(b.ld_ready), 0);
    chk("ra_cnt0", 32'(b.ld_count), 0);
    chk("ra_bos", 32'(b.bos), 32'h20);
    b.e = 1'b0; b.ld_valid = 1'b0;
    tick();
    reset = 1'b0;
    rd_chk("ra_m30", 8'h30, 8'h11);
    rd_chk("ra_m31", 8'h31, 8'h22);
    rd_chk("ra_m32", 8'h32, 8'h33);
    b.ld_start = 1'b1; b.ld_base = 8'h32;
    tick();
    b.ld_start = 1'b0; b.ld_valid = 1'b1; b.ld_data = 8'h44; b.ld_last = 1'b1;
    tick();
    b.ld_valid = 1'b0; b.ld_last = 1'b0;
    tick();
    chk("nl_count", 32'(b.ld_count), 1);
    rd_chk("nl_m32", 8'h32, 8'h44);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
